// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin selection of one byte source feeding a shared 8N1 serial transmitter
module uart_tx_arbiter #(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int NUM_REQ = 4,
  parameter int GAP_BITS = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       ser_tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       frame_done
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_q, bit_d;
  logic [IW-1:0] last_q, last_d, grant_q, grant_d;
  logic tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic win_found;
  logic [IW-1:0] win, cand;
  logic [7:0] sel_data;
  logic bit_end;
  // search from the requester after the last grant so the last winner ranks lowest
  always_comb begin
    win_found = 1'b0;
    win = '0;
    cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win = cand;
      end
    end
  end
  // byte of the current winner
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win == IW'(i)) sel_data = req_data[8*i +: 8];
  end
  assign req_ready = (state_q == IDLE && !reset && win_found) ? (NUM_REQ'(1) << win) : '0;
  assign bit_end = (cnt_q == '0);
  // next-state for frame sequencing, bit timing and registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q != IDLE) ? (bit_end ? CNT_LOAD : cnt_q - CW'(1)) : cnt_q;
    shift_d = shift_q;
    bit_d = bit_q;
    last_d = last_q;
    grant_d = grant_q;
    tx_d = tx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: if (win_found) begin
        shift_d = sel_data;
        grant_d = win;
        last_d = win;
        state_d = START;
        tx_d = 1'b0;
        busy_d = 1'b1;
        cnt_d = CNT_LOAD;
        bit_d = '0;
      end
      START: if (bit_end) begin
        state_d = DATA;
        tx_d = shift_q[0];
      end
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        if (bit_q == 4'd7) begin
          state_d = STOP;
          tx_d = 1'b1;
          bit_d = '0;
        end else begin
          tx_d = shift_q[1];
          bit_d = bit_q + 4'd1;
        end
      end
      STOP: if (bit_end) begin
        if (GAP_BITS > 0) state_d = GAP;
        else begin
          state_d = IDLE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      GAP: if (bit_end) begin
        if (bit_q == GAP_LAST) begin
          state_d = IDLE;
          busy_d = 1'b0;
          done_d = 1'b1;
          bit_d = '0;
        end else bit_d = bit_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register; reset aborts any frame without a completion pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shift_q <= '0;
      bit_q <= '0;
      last_q <= IW'(NUM_REQ - 1);
      grant_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      bit_q <= bit_d;
      last_q <= last_d;
      grant_q <= grant_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign ser_tx = tx_q;
  assign busy = busy_q;
  assign grant_id = grant_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration order, frame waveform, gap timing and reset abort
module tb_uart_tx_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] rv0 = '0, rv1 = '0;
  logic [31:0] rd0 = '0, rd1 = '0;
  logic [3:0] rdy0, rdy1;
  logic tx0, tx1, busy0, busy1, done0, done1;
  logic [1:0] gid0, gid1;
  int n_chk = 0;
  int n_pass = 0;
  uart_tx_arbiter #(.CLOCKS_PER_BIT(8), .NUM_REQ(4), .GAP_BITS(0)) u0 (
    .clock(clock), .reset(reset), .req_valid(rv0), .req_data(rd0), .req_ready(rdy0),
    .ser_tx(tx0), .busy(busy0), .grant_id(gid0), .frame_done(done0));
  uart_tx_arbiter #(.CLOCKS_PER_BIT(8), .NUM_REQ(4), .GAP_BITS(2)) u1 (
    .clock(clock), .reset(reset), .req_valid(rv1), .req_data(rd1), .req_ready(rdy1),
    .ser_tx(tx1), .busy(busy1), .grant_id(gid1), .frame_done(done1));
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask
  // called in the accept cycle; returns in the first IDLE cycle after the frame
  task automatic watch(input bit u, input int gap, input logic [7:0] b, input string tag);
    int bad;
    int last;
    logic e;
    bad = 0;
    last = (10 + gap) * 8;
    chk({tag, "_acc_tx"}, u ? tx1 : tx0, 1);
    for (int c = 1; c <= last; c++) begin
      tick;
      e = (c <= 8) ? 1'b0 : (c <= 72) ? b[(c - 9) / 8] : 1'b1;
      if ((u ? tx1 : tx0) !== e || (u ? busy1 : busy0) !== 1'b1 ||
          (u ? done1 : done0) !== 1'b0 || (u ? rdy1 : rdy0) !== 4'b0000) bad++;
    end
    chk({tag, "_wave_bad_cycles"}, bad, 0);
    tick;
    chk({tag, "_done"}, u ? done1 : done0, 1);
    chk({tag, "_busy"}, u ? busy1 : busy0, 0);
  endtask
  initial begin
    int bad;
    rv0 = 4'b0001;
    rd0 = {8'h13, 8'h12, 8'h11, 8'hA5};
    tick;
    tick;
    chk("rst_tx", tx0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_gid", gid0, 0);
    chk("rst_done", done0, 0);
    chk("rst_ready", rdy0, 4'b0000);
    reset = 1'b0;
    #1;
    chk("single_ready", rdy0, 4'b0001);
    watch(0, 0, 8'hA5, "single");
    rv0 = '0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    rv0 = 4'b1111;
    rd0 = {8'h13, 8'h12, 8'h11, 8'h10};
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("fair_ready%0d", k), rdy0, 4'b0001 << (k % 4));
      watch(0, 0, 8'h10 + 8'(k % 4), $sformatf("fair%0d", k));
      chk($sformatf("fair_gid%0d", k), gid0, k % 4);
    end
    rv0 = 4'b0101;
    #1;
    chk("wrap_ready_first", rdy0, 4'b0100);
    watch(0, 0, 8'h12, "wrap2");
    chk("wrap_gid2", gid0, 2);
    chk("wrap_ready_second", rdy0, 4'b0001);
    watch(0, 0, 8'h10, "wrap0");
    chk("wrap_gid0", gid0, 0);
    rv0 = 4'b0100;
    #1;
    chk("drop_ready", rdy0, 4'b0100);
    fork
      watch(0, 0, 8'h12, "drop");
      begin
        tick;
        rv0 = 4'b1000;
        repeat (40) tick;
        rv0 = 4'b0000;
      end
    join
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (rdy0 !== 4'b0000 || tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
      tick;
    end
    chk("drop_idle_bad_cycles", bad, 0);
    rv0 = 4'b0001;
    rd0 = {8'h13, 8'h12, 8'h11, 8'hA5};
    #1;
    chk("abort_ready", rdy0, 4'b0001);
    for (int c = 1; c <= 30; c++) begin
      tick;
      if (c == 1) rv0 = 4'b0000;
    end
    chk("abort_busy_before", busy0, 1);
    reset = 1'b1;
    rv0 = 4'b1010;
    tick;
    chk("abort_tx", tx0, 1);
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_ready_in_reset", rdy0, 4'b0000);
    reset = 1'b0;
    #1;
    chk("abort_ready_after", rdy0, 4'b0010);
    watch(0, 0, 8'h11, "abort_next");
    chk("abort_next_gid", gid0, 1);
    rv0 = 4'b0000;
    rv1 = 4'b0010;
    rd1 = {8'h00, 8'h00, 8'h5C, 8'h00};
    #1;
    chk("gap_ready_first", rdy1, 4'b0010);
    watch(1, 2, 8'h5C, "gap1");
    chk("gap_ready_period", rdy1, 4'b0010);
    watch(1, 2, 8'h5C, "gap2");
    chk("gap_gid", gid1, 1);
    rv1 = 4'b0000;
    tick;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
